// File: rtl/dual_acc_collector.sv
// dual_acc_collector
//   Receive end of the dual-multiplier result stream. Accumulates TAPS
//   consecutive valid product pairs into two independent signed sums
//   (channel A from ac_in, channel B from bc_in) and presents each completed
//   pair on a one-entry valid/ready output register. The upstream multiplier
//   cannot be stalled, so a completed group that finds the output slot
//   occupied is dropped and flagged on the sticky overflow_err.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   valid_in     product pair valid (multiplier valid_out)
//   ac_in        signed channel-A product
//   bc_in        signed channel-B product
//   clr          discard the partial group, restart at tap 0
//   acc_a        signed channel-A group sum
//   acc_b        signed channel-B group sum
//   out_valid    acc_a/acc_b hold an undelivered result
//   out_ready    downstream accepts when out_valid & out_ready
//   tap_idx      index of the next expected tap (0..TAPS-1)
//   overflow_err sticky: a completed group was dropped
module dual_acc_collector #(
    parameter int unsigned TAPS  = 9,
    parameter int unsigned ACC_W = 24,
    parameter int unsigned CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic signed [15:0]      ac_in,
    input  logic signed [15:0]      bc_in,
    input  logic                    clr,
    output logic signed [ACC_W-1:0] acc_a,
    output logic signed [ACC_W-1:0] acc_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CNT_W-1:0]        tap_idx,
    output logic                    overflow_err
);

    localparam logic [CNT_W-1:0] LastTap = CNT_W'(TAPS - 1);

    // Tap counter and partial sums
    logic [CNT_W-1:0]        tap_q, tap_d;
    logic signed [ACC_W-1:0] part_a_q, part_a_d;
    logic signed [ACC_W-1:0] part_b_q, part_b_d;

    // Output register
    logic signed [ACC_W-1:0] acc_a_q, acc_a_d;
    logic signed [ACC_W-1:0] acc_b_q, acc_b_d;
    logic                    out_valid_q, out_valid_d;
    logic                    err_q, err_d;

    // Datapath intermediates
    logic [CNT_W-1:0]        eff_tap;
    logic                    group_start;
    logic                    last_tap;
    logic                    complete;
    logic                    slot_free;
    logic signed [ACC_W-1:0] ext_a, ext_b;
    logic signed [ACC_W-1:0] base_a, base_b;
    logic signed [ACC_W-1:0] sum_a, sum_b;

    // clr takes effect in the same cycle: a coincident beat is treated as
    // tap 0 of a fresh group, so everything below works on eff_tap.
    always_comb begin
        eff_tap     = clr ? '0 : tap_q;
        group_start = (eff_tap == '0);
        last_tap    = (eff_tap == LastTap);
        complete    = valid_in && last_tap;
        slot_free   = !out_valid_q || out_ready;

        ext_a  = ACC_W'(ac_in);
        ext_b  = ACC_W'(bc_in);
        // Tap 0 loads rather than adds, so stale partials never leak in.
        base_a = group_start ? '0 : part_a_q;
        base_b = group_start ? '0 : part_b_q;
        sum_a  = base_a + ext_a;
        sum_b  = base_b + ext_b;
    end

    // Next-state for the tap counter and partial sums
    always_comb begin
        tap_d    = tap_q;
        part_a_d = part_a_q;
        part_b_d = part_b_q;
        if (valid_in) begin
            if (last_tap) begin
                tap_d    = '0;
                part_a_d = '0;
                part_b_d = '0;
            end else begin
                tap_d    = eff_tap + CNT_W'(1);
                part_a_d = sum_a;
                part_b_d = sum_b;
            end
        end else if (clr) begin
            tap_d    = '0;
            part_a_d = '0;
            part_b_d = '0;
        end
    end

    // Next-state for the output slot. A drain and a new completion in the
    // same cycle swap the contents without a bubble.
    always_comb begin
        acc_a_d     = acc_a_q;
        acc_b_d     = acc_b_q;
        out_valid_d = out_valid_q;
        err_d       = err_q;
        if (complete) begin
            if (slot_free) begin
                acc_a_d     = sum_a;
                acc_b_d     = sum_b;
                out_valid_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tap_q       <= '0;
            part_a_q    <= '0;
            part_b_q    <= '0;
            acc_a_q     <= '0;
            acc_b_q     <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            tap_q       <= tap_d;
            part_a_q    <= part_a_d;
            part_b_q    <= part_b_d;
            acc_a_q     <= acc_a_d;
            acc_b_q     <= acc_b_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign acc_a        = acc_a_q;
    assign acc_b        = acc_b_q;
    assign out_valid    = out_valid_q;
    assign tap_idx      = tap_q;
    assign overflow_err = err_q;

endmodule

// File: tb/tb_dual_acc_collector.sv
// Bench for dual_acc_collector: a TAPS=9/ACC_W=24 instance and a
// TAPS=1/ACC_W=16 instance share stimulus; a group-level model tracks both
// and is compared every cycle, with literal checks at key points.
module tb_dual_acc_collector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, valid_in, clr, out_ready;
    logic signed [15:0] ac_in, bc_in;

    logic signed [23:0] acc_a0, acc_b0;
    logic               out_valid0, err0;
    logic [3:0]         tap0;

    logic signed [15:0] acc_a1, acc_b1;
    logic               out_valid1, err1;
    logic [0:0]         tap1;

    dual_acc_collector #(.TAPS(9), .ACC_W(24)) u_dut9 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ac_in(ac_in), .bc_in(bc_in),
        .clr(clr), .acc_a(acc_a0), .acc_b(acc_b0), .out_valid(out_valid0),
        .out_ready(out_ready), .tap_idx(tap0), .overflow_err(err0)
    );

    dual_acc_collector #(.TAPS(1), .ACC_W(16)) u_dut1 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ac_in(ac_in), .bc_in(bc_in),
        .clr(clr), .acc_a(acc_a1), .acc_b(acc_b1), .out_valid(out_valid1),
        .out_ready(out_ready), .tap_idx(tap1), .overflow_err(err1)
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic check(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Group-level model: count beats, keep running sums, hand completed
    // groups to a one-entry slot.
    typedef struct packed {
        int n;
        int sa;
        int sb;
        bit mv;
        int ma;
        int mb;
        bit err;
    } model_t;

    function automatic model_t step(model_t m, int taps, bit r, bit v, bit c,
                                    int a, int b, bit rdy);
        model_t s;
        bit done;
        int fa, fb;
        s = m;
        done = 1'b0;
        fa = 0;
        fb = 0;
        if (r) begin
            s = '0;
            return s;
        end
        if (c) begin
            s.n = 0; s.sa = 0; s.sb = 0;
        end
        if (v) begin
            s.sa += a;
            s.sb += b;
            s.n++;
            if (s.n == taps) begin
                done = 1'b1;
                fa = s.sa; fb = s.sb;
                s.n = 0; s.sa = 0; s.sb = 0;
            end
        end
        if (done) begin
            if (!s.mv || rdy) begin
                s.ma = fa; s.mb = fb; s.mv = 1'b1;
            end else begin
                s.err = 1'b1;
            end
        end else if (s.mv && rdy) begin
            s.mv = 1'b0;
        end
        return s;
    endfunction

    model_t m0 = '0;
    model_t m1 = '0;

    always @(posedge clk) begin
        m0 <= step(m0, 9, rst, valid_in, clr, int'(ac_in), int'(bc_in), out_ready);
        m1 <= step(m1, 1, rst, valid_in, clr, int'(ac_in), int'(bc_in), out_ready);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("t9.out_valid", int'(out_valid0), int'(m0.mv));
            check("t9.acc_a", int'(acc_a0), m0.ma);
            check("t9.acc_b", int'(acc_b0), m0.mb);
            check("t9.tap_idx", int'(tap0), m0.n);
            check("t9.overflow_err", int'(err0), int'(m0.err));
            check("t1.out_valid", int'(out_valid1), int'(m1.mv));
            check("t1.acc_a", int'(acc_a1), m1.ma);
            check("t1.acc_b", int'(acc_b1), m1.mb);
            check("t1.tap_idx", int'(tap1), m1.n);
            check("t1.overflow_err", int'(err1), int'(m1.err));
        end
    end

    // Inputs change 2 time units after the rising edge.
    task automatic drive(bit r, bit v, int a, int b, bit c, bit rd);
        @(posedge clk);
        #2;
        rst       = r;
        valid_in  = v;
        ac_in     = 16'(a);
        bc_in     = 16'(b);
        clr       = c;
        out_ready = rd;
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; clr = 1'b0; out_ready = 1'b0;
        ac_in = '0; bc_in = '0;

        // Reset with random inputs
        drive(1, 1'($urandom), int'($urandom), int'($urandom), 1'($urandom), 1'($urandom));
        drive(1, 1'($urandom), int'($urandom), int'($urandom), 1'($urandom), 1'($urandom));
        drive(0, 0, 0, 0, 0, 1);
        check("rst.acc_a", int'(acc_a0), 0);
        check("rst.acc_b", int'(acc_b0), 0);
        check("rst.out_valid", int'(out_valid0), 0);
        check("rst.overflow_err", int'(err0), 0);
        check("rst.tap_idx", int'(tap0), 0);
        chk_en = 1'b1;

        // Basic group, back-to-back
        for (int i = 0; i < 9; i++) drive(0, 1, 100, -3, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        check("basic.acc_a", int'(acc_a0), 900);
        check("basic.acc_b", int'(acc_b0), -27);
        check("basic.out_valid", int'(out_valid0), 1);
        check("basic.tap_idx", int'(tap0), 0);
        drive(0, 0, 0, 0, 0, 1);
        check("basic.one_pulse", int'(out_valid0), 0);

        // Extremes with gaps
        for (int i = 0; i < 9; i++) begin
            drive(0, 1, -32768, 32767, 0, 1);
            drive(0, 0, 0, 0, 0, 1);
        end
        check("ext.acc_a", int'(acc_a0), -294912);
        check("ext.acc_a_raw", int'($unsigned(acc_a0)), 32'h00FB8000);
        check("ext.acc_b", int'(acc_b0), 294903);
        check("ext.out_valid", int'(out_valid0), 1);

        // Backpressure: second group is dropped
        for (int i = 0; i < 9; i++) drive(0, 1, 1, 1, 0, 0);
        for (int i = 0; i < 9; i++) drive(0, 1, 2, 2, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        check("bp.acc_a", int'(acc_a0), 9);
        check("bp.acc_b", int'(acc_b0), 9);
        check("bp.out_valid", int'(out_valid0), 1);
        check("bp.overflow_err", int'(err0), 1);
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        check("bp.drained", int'(out_valid0), 0);
        check("bp.err_sticky", int'(err0), 1);

        // Simultaneous drain and load
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) drive(0, 1, 1, 1, 0, 0);
        for (int i = 0; i < 8; i++) drive(0, 1, 2, 2, 0, 0);
        check("swap.held", int'(acc_a0), 9);
        drive(0, 1, 2, 2, 0, 1);
        drive(0, 0, 0, 0, 0, 0);
        check("swap.acc_a", int'(acc_a0), 18);
        check("swap.out_valid", int'(out_valid0), 1);
        check("swap.overflow_err", int'(err0), 0);
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);

        // clr on an idle cycle
        for (int i = 0; i < 4; i++) drive(0, 1, 5, 5, 0, 1);
        drive(0, 0, 0, 0, 1, 1);
        check("clr.tap_before", int'(tap0), 4);
        for (int i = 0; i < 9; i++) drive(0, 1, 1, 1, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        check("clr.acc_a", int'(acc_a0), 9);
        check("clr.acc_b", int'(acc_b0), 9);

        // clr coincident with first beat
        for (int i = 0; i < 4; i++) drive(0, 1, 5, 5, 0, 1);
        drive(0, 1, 1, 1, 1, 1);
        drive(0, 1, 1, 1, 0, 1);
        check("clrv.tap", int'(tap0), 1);
        for (int i = 0; i < 7; i++) drive(0, 1, 1, 1, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        check("clrv.acc_a", int'(acc_a0), 9);
        check("clrv.out_valid", int'(out_valid0), 1);

        // TAPS=1: each beat appears the next cycle
        drive(0, 1, 7, -7, 0, 1);
        drive(0, 1, -300, 300, 0, 1);
        check("t1.beat1_a", int'(acc_a1), 7);
        check("t1.beat1_b", int'(acc_b1), -7);
        check("t1.beat1_v", int'(out_valid1), 1);
        drive(0, 0, 0, 0, 0, 1);
        check("t1.beat2_a", int'(acc_a1), -300);
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dual_acc_collector.md
Name: dual_acc_collector

Overview:
- Receive end of the dual-multiplier result stream: consumes the packed-product outputs (ac, bc, valid) of the conv1 dual-mult DSP stage.
- Accumulates TAPS consecutive valid product pairs per output pixel into two independent signed accumulators: channel A from ac, channel B from bc.
- Presents each completed pair of sums on a one-entry valid/ready output register toward requant/writeback.
- Sits directly downstream of the dual multiplier, which has no backpressure; lost results are flagged, not stalled.

Parameters:
- TAPS, 9, products per output group (kernel taps). Legal range 1..256.
- ACC_W, 24, accumulator and output width. Must be ≥ 16 + clog2(TAPS), so no overflow is possible inside a group.
- CNT_W, (TAPS>1 ? clog2(TAPS) : 1), tap counter width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- valid_in  in  1  product pair valid; driven by the multiplier's valid_out
- ac_in  in  16  signed channel-A product
- bc_in  in  16  signed channel-B product
- clr  in  1  discard the partial group and restart at tap 0
- acc_a  out  ACC_W  signed channel-A group sum
- acc_b  out  ACC_W  signed channel-B group sum
- out_valid  out  1  acc_a/acc_b hold an undelivered result
- out_ready  in  1  downstream accepts the result when out_valid & out_ready
- tap_idx  out  CNT_W  index of the next expected tap (0..TAPS-1)
- overflow_err  out  1  sticky: a completed group was dropped

Behaviour:
- Reset (synchronous, rst=1): tap_idx=0, internal partials=0, acc_a=0, acc_b=0, out_valid=0, overflow_err=0. Reset mid-group discards the partial group and any held result.
- Cycles with valid_in=0 change nothing except the output handshake. Gaps between taps are allowed.
- Tap accumulation on valid_in=1:
  - Inputs are sign-extended to ACC_W.
  - tap_idx==0: partial_a/b load the input (no add).
  - Otherwise: partial_a/b <= partial + input.
  - tap_idx increments modulo TAPS.
- Completion: a valid_in beat with tap_idx==TAPS-1 completes the group.
  - final = partial + input (or the input alone if TAPS==1).
  - tap_idx returns to 0.
- Output register, evaluated each cycle:
  - Slot is free when out_valid==0, or when out_valid & out_ready in this cycle.
  - Completion with slot free: acc_a/acc_b <= final, out_valid <= 1.
  - Completion with slot not free: final is dropped, overflow_err <= 1, acc_a/acc_b/out_valid unchanged.
  - No completion, and out_valid & out_ready: out_valid <= 0. acc_a/acc_b keep their last values.
  - acc_a/acc_b are stable while out_valid=1 and out_ready=0.
- Latency: the final tap sampled at edge t gives out_valid=1 after edge t. No bubble is needed between back-to-back groups when out_ready=1.
- clr:
  - Sets tap_idx to 0 and discards partials. Does not touch the output register or overflow_err.
  - clr and valid_in in the same cycle: the incoming beat is taken as tap 0 of a new group (tap_idx <= 1, or completes if TAPS==1).
- overflow_err clears only on rst.
- tap_idx is registered and reflects state after the last edge.

Test Plan:
- Reset: assert rst 2 cycles with random inputs -> all outputs 0, out_valid=0, overflow_err=0.
- Basic group (TAPS=9, ACC_W=24): 9 back-to-back beats ac=100, bc=-3, out_ready=1 -> one cycle after beat 9: out_valid=1 for exactly 1 cycle, acc_a=900, acc_b=-27, tap_idx=0.
- Extremes with gaps: 9 beats ac=-32768, bc=32767, one idle cycle between beats -> acc_a=-294912 (0xFB8000), acc_b=294903; no extra out_valid pulses.
- Backpressure:
  - out_ready=0, group1 all ac=bc=1, then group2 all ac=bc=2 -> acc_a=acc_b=9 held, overflow_err=1.
  - Then out_ready=1 -> one transfer of 9, out_valid=0, overflow_err stays 1.
- Simultaneous drain and load: out_valid=1 holding 9; out_ready=1 on the same cycle as group-completion beat (sum 18) -> out_valid stays 1, acc_a=18, overflow_err=0.
- clr:
  - 4 beats of 5, then clr, then 9 beats of 1 -> result 9.
  - Repeat with clr coincident with the first beat of 1 -> still 9. TAPS=1 build: every beat appears on the outputs the next cycle.
